result_writer: RTL

Sink for the 19-bit convolution result stream produced by the layer-0 convolution engine. Applies ReLU, writes every result to the layer-0 result memory, and computes the 2x2/stride-2 max-pool into the layer-1 result memory over a single shared write port. Sits between the convolution engine output (`o_valid`/`o_data`) and the testbench-side result memories, and signals frame completion.

---
 rtl/result_writer_if.sv | 25 ++
 rtl/result_writer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/result_writer_if.sv
// Result-writer bus: convolution result stream in,
// shared result-memory write port and frame status out.
interface result_writer_if;
  logic        i_start;
  logic        i_valid;
  logic [18:0] i_data;
  logic        o_cwr;
  logic        o_sel;
  logic [11:0] o_caddr;
  logic [19:0] o_cdata;
  logic        o_done;
  logic        o_err;

  modport slave (
    input  i_start, i_valid, i_data,
    output o_cwr, o_sel, o_caddr,
    output o_cdata, o_done, o_err
  );

  modport master (
    output i_start, i_valid, i_data,
    input  o_cwr, o_sel, o_caddr,
    input  o_cdata, o_done, o_err
  );
endinterface

// File: rtl/result_writer.sv
// ReLU + layer-0 writeback + 2x2 max-pool into layer-1,
// both sharing one registered memory write port.
module result_writer #(
  parameter int IMG_W      = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  result_writer_if.slave  bus
);
  localparam int LW = $clog2(IMG_W);
  localparam int NW = 2 * LW;
  localparam int HW = IMG_W / 2;
  localparam int FW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE, RUN, DRAIN, DONE
  } state_e;

  typedef struct packed {
    logic [11:0] addr;
    logic [18:0] data;
  } pool_t;

  state_e state_q, state_d;

  logic [NW-1:0] n_q, n_d;
  logic [18:0]   h_q, h_d;
  logic [18:0]   rb_q [HW];
  logic [18:0]   rb_d [HW];
  pool_t         fifo_q [FIFO_DEPTH];
  pool_t         fifo_d [FIFO_DEPTH];
  logic [FW-1:0] rd_q, rd_d;
  logic [FW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          cwr_q, cwr_d;
  logic          sel_q, sel_d;
  logic [11:0]   caddr_q, caddr_d;
  logic [19:0]   cdata_q, cdata_d;
  logic          done_q, done_d;

  logic          accept, push, pop;
  logic          last, full;
  logic [18:0]   v, mx_h, mx_rb;
  logic [LW-2:0] hcol;
  logic [11:0]   paddr;

  function automatic logic [FW-1:0] inc(
    input logic [FW-1:0] p
  );
    if (p == FW'(FIFO_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  always_comb begin
    v      = bus.i_data[18] ? '0 : bus.i_data;
    accept = (state_q == RUN) && bus.i_valid;
    hcol   = n_q[LW-1:1];
    last   = &n_q;
    full   = cnt_q == CW'(FIFO_DEPTH);
    mx_h   = (h_q > v) ? h_q : v;
    mx_rb  = (rb_q[hcol] > v) ? rb_q[hcol] : v;
    paddr  = 12'({n_q[NW-1:LW+1], n_q[LW-1:1]});
    push   = accept && n_q[LW] && n_q[0];
    // layer-0 writes own the port; the queue only fills gaps
    pop    = !accept && (cnt_q != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (bus.i_start)     state_d = RUN;
      RUN:   if (accept && last)  state_d = DRAIN;
      DRAIN: if (cnt_q == '0)     state_d = DONE;
      DONE:                       state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  always_comb begin
    cwr_d   = 1'b0;
    sel_d   = sel_q;
    caddr_d = caddr_q;
    cdata_d = cdata_q;
    done_d  = (state_q == DRAIN) && (cnt_q == '0);
    if (accept) begin
      cwr_d   = 1'b1;
      sel_d   = 1'b0;
      caddr_d = 12'(n_q);
      cdata_d = {1'b0, v};
    end else if (pop) begin
      cwr_d   = 1'b1;
      sel_d   = 1'b1;
      caddr_d = fifo_q[rd_q].addr;
      cdata_d = {1'b0, fifo_q[rd_q].data};
    end
  end

  always_comb begin
    n_d    = n_q;
    h_d    = h_q;
    rb_d   = rb_q;
    fifo_d = fifo_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (state_q == IDLE && bus.i_start) begin
      n_d   = '0;
      h_d   = '0;
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (accept) begin
        n_d = n_q + 1'b1;
        unique case ({n_q[LW], n_q[0]})
          2'b00: h_d = v;
          2'b01: rb_d[hcol] = mx_h;
          2'b10: h_d = mx_rb;
          default: ;
        endcase
      end
      if (pop) begin
        rd_d  = inc(rd_q);
        cnt_d = cnt_q - 1'b1;
      end
      if (push) begin
        if (full && !pop) begin
          err_d = 1'b1;
        end else begin
          fifo_d[wr_q].addr = paddr;
          fifo_d[wr_q].data = mx_h;
          wr_d  = inc(wr_q);
          cnt_d = cnt_d + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q     <= '0;
      h_q     <= '0;
      rb_q    <= '{default: '0};
      fifo_q  <= '{default: '0};
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      cwr_q   <= 1'b0;
      sel_q   <= 1'b0;
      caddr_q <= '0;
      cdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      n_q     <= n_d;
      h_q     <= h_d;
      rb_q    <= rb_d;
      fifo_q  <= fifo_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      cwr_q   <= cwr_d;
      sel_q   <= sel_d;
      caddr_q <= caddr_d;
      cdata_q <= cdata_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_cwr   = cwr_q;
  assign bus.o_sel   = sel_q;
  assign bus.o_caddr = caddr_q;
  assign bus.o_cdata = cdata_q;
  assign bus.o_done  = done_q;
  assign bus.o_err   = err_q;
endmodule
